// File: rtl/stack_prog_loader_pkg.sv
// stackCPU_DEFS: shared defaults and loader state encoding for the stack CPU program loader.
package stackCPU_DEFS;
    localparam int INSTR_WIDTH_DEF    = 16;
    localparam int PC_WIDTH_DEF       = 8;
    localparam int PGRM_MEM_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        CSUM,
        RUN,
        ERR
    } loader_state_e;
endpackage

// File: rtl/stack_prog_loader_mem.sv
// stack_prog_mem: program store with one synchronous write port and an asynchronous read port.
module stack_prog_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/stack_prog_loader.sv
// stack_prog_loader: loads a length-prefixed byte stream into program memory, then releases the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before RUN.
module stack_prog_loader
    import stackCPU_DEFS::*;
#(
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int MEM_DEPTH   = PGRM_MEM_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   cpu_reset,
    output logic                   load_done,
    output logic                   load_error,
    input  logic                   start,
    output logic                   out_of_range
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e DONE_ST = CSUM;
`else
    localparam loader_state_e DONE_ST = RUN;
`endif

    loader_state_e state_q, state_d;
    logic [15:0] n_q, n_d, wr_q, wr_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] hdr;
    logic        accept, we, masked;
    logic [INSTR_WIDTH-1:0] rdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign in_ready = (state_q != RUN) && (state_q != ERR);
    assign accept   = in_valid && in_ready;
    assign hdr      = {hi_q, in_data};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        we      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            HDR_HI: if (accept) begin
                hi_d    = in_data;
                state_d = HDR_LO;
            end
            HDR_LO: if (accept) begin
                if (hdr > 16'(MEM_DEPTH)) state_d = ERR;
                else begin
                    n_d     = hdr;
                    state_d = (hdr == 16'd0) ? DONE_ST : DATA_HI;
                end
            end
            DATA_HI: if (accept) begin
                hi_d    = in_data;
                state_d = DATA_LO;
            end
            DATA_LO: if (accept) begin
                we      = 1'b1;
                wr_d    = wr_q + 16'd1;
                state_d = (wr_d == n_q) ? DONE_ST : DATA_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: if (accept) state_d = (in_data == csum_q) ? RUN : ERR;
`endif
            RUN, ERR: if (start) begin
                state_d = HDR_HI;
                n_d     = '0;
                wr_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            default: state_d = HDR_HI;
        endcase
`ifdef LOADER_CHECKSUM_EN
        if (accept && state_q != CSUM) csum_d = csum_q ^ in_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= HDR_HI;
            n_q     <= '0;
            wr_q    <= '0;
            hi_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    stack_prog_mem #(
        .WIDTH(INSTR_WIDTH),
        .DEPTH(MEM_DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk    (clk),
        .we_i   (we),
        .waddr_i(AW'(wr_q)),
        .wdata_i(INSTR_WIDTH'({hi_q, in_data})),
        .raddr_i(AW'(pc)),
        .rdata_o(rdata)
    );

    // Words at or beyond the write pointer are still stale from an earlier load.
    assign out_of_range = 32'(pc) >= 32'(n_q);
    assign masked       = out_of_range || (32'(pc) >= 32'(wr_q));
    assign instruction  = masked ? '1 : rdata;
    assign cpu_reset    = state_q != RUN;
    assign load_done    = state_q == RUN;
    assign load_error   = state_q == ERR;
endmodule

// File: tb/tb_stack_prog_loader.sv
// tb_stack_prog_loader: directed load streams with a scoreboard queue checked by a negedge monitor.
module tb_stack_prog_loader;
    localparam int IW = 16, PW = 8, MD = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam logic [3:0] ST_LOAD = 4'b1100;
    localparam logic [3:0] ST_RUN  = 4'b0010;
    localparam logic [3:0] ST_ERR  = 4'b0101;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [4:0]  flags;
    } exp_t;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, start = 1'b0, probe = 1'b0;
    logic [7:0] in_data = '0;
    logic [PW-1:0] pc = '0;
    logic [IW-1:0] instruction;
    logic in_ready, cpu_reset, load_done, load_error, out_of_range;
    logic [4:0] act;
    exp_t q[$];
    exp_t e;
    bq_t bs;
    int checks = 0, failures = 0;

    stack_prog_loader #(.INSTR_WIDTH(IW), .PC_WIDTH(PW), .MEM_DEPTH(MD)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .instruction(instruction), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_error(load_error), .start(start), .out_of_range(out_of_range)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (probe) begin
            checks++;
            act = {out_of_range, in_ready, cpu_reset, load_done, load_error};
            if (q.size() == 0) begin
                failures++;
                $display("FAIL probe_without_expectation: instr=%h flags=%b", instruction, act);
            end else begin
                e = q.pop_front();
                if (instruction !== e.instr || act !== e.flags) begin
                    failures++;
                    $display("FAIL %s: got instr=%h flags(oor,rdy,rst,done,err)=%b expected instr=%h flags=%b",
                             e.name, instruction, act, e.instr, e.flags);
                end
            end
        end
    end

    task automatic chk(input string name, input int p, input logic [15:0] instr, input logic oor,
                       input logic [3:0] st);
        exp_t x;
        pc = PW'(p);
        x.name = name; x.instr = instr; x.flags = {oor, st};
        q.push_back(x);
        probe = 1'b1;
        @(posedge clk); #1 probe = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = b;
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic load(input bit gaps);
        logic [7:0] cs = 8'h00;
        foreach (bs[i]) begin
            cs ^= bs[i];
            send(bs[i], gaps ? int'($urandom_range(0, 3)) : 0);
        end
        if (CS) send(cs, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset_state", 0, 16'hFFFF, 1'b1, ST_LOAD);

        send(8'h00, 0); send(8'h02, 0); send(8'h00, 0); send(8'h05, 0);
        chk("midload_pc0", 0, 16'h0005, 1'b0, ST_LOAD);
        chk("midload_pc1_unwritten", 1, 16'hFFFF, 1'b0, ST_LOAD);
        send(8'h08, 2); send(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("await_csum", 1, 16'h0800, 1'b0, ST_LOAD);
        send(8'h0F, 0);
`endif
        chk("run_pc0", 0, 16'h0005, 1'b0, ST_RUN);
        chk("run_pc1", 1, 16'h0800, 1'b0, ST_RUN);
        chk("run_pc2_oor", 2, 16'hFFFF, 1'b1, ST_RUN);
        send(8'h55, 0);
        chk("run_ignores_bytes", 0, 16'h0005, 1'b0, ST_RUN);

        pulse_start();
        chk("start_from_run", 0, 16'hFFFF, 1'b1, ST_LOAD);
        bs = '{8'h00, 8'h00}; load(1'b0);
        chk("empty_prog_run", 0, 16'hFFFF, 1'b1, ST_RUN);

        pulse_start();
        send(8'h00, 0); send(8'h11, 0);
        chk("too_long_err", 0, 16'hFFFF, 1'b1, ST_ERR);
        send(8'h00, 0);
        repeat (3) @(posedge clk); #1;
        chk("err_held", 0, 16'hFFFF, 1'b1, ST_ERR);
        pulse_start();
        chk("start_from_err", 0, 16'hFFFF, 1'b1, ST_LOAD);

        bs = {}; bs.push_back(8'h00); bs.push_back(8'h10);
        for (int i = 0; i < MD; i++) begin bs.push_back(8'(i)); bs.push_back(8'(i)); end
        load(1'b0);
        chk("full_depth_pc0", 0, 16'h0000, 1'b0, ST_RUN);
        chk("full_depth_pc15", 15, 16'h0F0F, 1'b0, ST_RUN);
        chk("full_depth_pc16_oor", 16, 16'hFFFF, 1'b1, ST_RUN);

        for (int g = 0; g < 2; g++) begin
            pulse_start();
            bs = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h7F};
            load(g == 1);
            chk(g ? "gaps_pc0" : "nogap_pc0", 0, 16'h1234, 1'b0, ST_RUN);
            chk(g ? "gaps_pc1" : "nogap_pc1", 1, 16'hABCD, 1'b0, ST_RUN);
            chk(g ? "gaps_pc2" : "nogap_pc2", 2, 16'h007F, 1'b0, ST_RUN);
            chk(g ? "gaps_pc3_oor" : "nogap_pc3_oor", 3, 16'hFFFF, 1'b1, ST_RUN);
        end

        pulse_start();
        send(8'h00, 0); send(8'h02, 0);
        pulse_start();
        send(8'h00, 0);
        chk("start_ignored_midload", 0, 16'hFFFF, 1'b0, ST_LOAD);
        reset = 1'b0; @(posedge clk); #1 reset = 1'b1;
        chk("reset_midload", 0, 16'hFFFF, 1'b1, ST_LOAD);
        bs = '{8'h00, 8'h02, 8'h00, 8'h05, 8'h08, 8'h00}; load(1'b0);
        chk("reload_pc0", 0, 16'h0005, 1'b0, ST_RUN);
        chk("reload_pc1", 1, 16'h0800, 1'b0, ST_RUN);

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        send(8'h00, 0); send(8'h01, 0); send(8'h08, 0); send(8'h00, 0); send(8'h09, 0);
        chk("csum_good_run", 0, 16'h0800, 1'b0, ST_RUN);
        pulse_start();
        send(8'h00, 0); send(8'h01, 0); send(8'h08, 0); send(8'h00, 0); send(8'h0A, 0);
        chk("csum_bad_err", 0, 16'h0800, 1'b0, ST_ERR);
`endif

        @(posedge clk); #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stack_prog_loader.md
STACK_PROG_LOADER -- requirements
Module: stack_prog_loader

Interface
REQ-001 SHALL take parameter INSTR_WIDTH, default INSTR_WIDTH_DEF (16), instruction word width.
REQ-002 SHALL take parameter PC_WIDTH, default PC_WIDTH_DEF, program-counter width.
REQ-003 SHALL take parameter MEM_DEPTH, default PGRM_MEM_DEPTH_DEF, number of program words stored.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports in_data, in_valid and in_ready: in_data input 8, load byte stream; in_valid input 1, byte present; in_ready output 1, loader accepts byte.
REQ-007 SHALL have ports pc and instruction: pc input PC_WIDTH, CPU fetch address; instruction output INSTR_WIDTH, word at pc.
REQ-008 SHALL have ports cpu_reset, load_done and load_error, each output 1: CPU held in reset (active-high); program loaded and CPU released; load aborted.
REQ-009 SHALL have ports start input 1, re-arm loader from RUN/ERR, and out_of_range output 1, pc >= loaded word count.

Function
REQ-010 SHALL implement states HDR_HI, HDR_LO, DATA_HI, DATA_LO, CSUM, RUN, ERR.
REQ-011 SHALL accept a byte only on a rising edge where in_valid && in_ready.
REQ-012 SHALL drive in_ready=1 in HDR_HI/HDR_LO/DATA_HI/DATA_LO/CSUM and in_ready=0 in RUN/ERR.
REQ-013 SHALL take the header as a big-endian 16-bit word count N: HDR_HI -> HDR_LO -> DATA_HI on accepted bytes.
REQ-014 SHALL send N>MEM_DEPTH to ERR, and N=0 to CSUM (macro on) or RUN (macro off), on the HDR_LO acceptance edge.
REQ-015 SHALL take each instruction as high byte (DATA_HI) then low byte (DATA_LO).
REQ-016 SHALL write mem[wr_addr] on the DATA_LO acceptance edge, then increment wr_addr (reset 0).
REQ-017 SHALL, after the Nth word, go to CSUM (macro on) or RUN (macro off); otherwise DATA_LO -> DATA_HI.
REQ-018 SHALL drive instruction = mem[pc] combinationally, zero latency, in every state.
REQ-019 SHALL, when pc >= N, drive out_of_range=1 and instruction all-ones; not-yet-written words SHALL never be visible.
REQ-020 SHALL drive cpu_reset=1 in every state except RUN, and load_done=1 only in RUN.
REQ-021 SHALL drive load_error=1 only in ERR; ERR is held until start or reset.
REQ-022 SHALL, on start=1 in RUN or ERR, go to HDR_HI and clear N, wr_addr and checksum; start SHALL be ignored in other states.
REQ-023 SHALL hold state and counters unchanged on cycles with in_valid=0 (stalls of any length).

Reset
REQ-024 SHALL, with reset=0 at a rising edge, set state HDR_HI and N=0, wr_addr=0, checksum=0, regardless of state, including mid-load.
REQ-025 SHALL produce reset output values in_ready=1, cpu_reset=1, load_done=0, load_error=0, out_of_range=1.
REQ-026 SHALL NOT reset memory contents; N=0 masks them via REQ-019.

Configuration
REQ-027 SHALL, with LOADER_CHECKSUM_EN defined, XOR every accepted header and data byte into an 8-bit checksum.
REQ-028 SHALL, with LOADER_CHECKSUM_EN defined, compare one trailing byte in CSUM: equal -> RUN, unequal -> ERR.
REQ-029 SHALL, without LOADER_CHECKSUM_EN, contain no checksum register or CSUM transitions; load completes without a trailing byte.

Structure
REQ-030 SHALL place the loader state enum, INSTR_WIDTH_DEF, PC_WIDTH_DEF and PGRM_MEM_DEPTH_DEF in package stackCPU_DEFS.
REQ-031 SHALL use one sub-module stack_prog_mem (single write port, asynchronous read).

Verification
REQ-032 SHALL cover: macro off, bytes 00 02 00 05 08 00 -> RUN after 6 accepts; pc=0 gives 0x0005, pc=1 gives 0x0800, pc=2 gives 0xFFFF with out_of_range=1.
REQ-033 SHALL cover: header 00 00 with macro off -> RUN on 2nd accept, load_done=1, cpu_reset=0.
REQ-034 SHALL cover: header with N=MEM_DEPTH+1 -> ERR, load_error=1, in_ready=0; start=1 -> HDR_HI.
REQ-035 SHALL cover: macro on, bytes 00 01 08 00 then 09 -> RUN; same stream with trailing 0A -> ERR.
REQ-036 SHALL cover: random in_valid gaps during load -> same memory image as gap-free load.
REQ-037 SHALL cover: reset=0 after 3 of 6 bytes -> HDR_HI, out_of_range=1; full reload then succeeds.
